// File: rtl/tdc_meas_ctrl.sv
// tdc_meas_ctrl
// -------------
// Measurement sequencer for a TDC delay line. It fires one start pulse into
// the line, snapshots the tap vector one clock later, passes the snapshot
// through a second register to settle metastability, then turns the
// thermometer code into a ones count with overflow and bubble flags. The
// result goes out over a valid/ready handshake. Before the next start is
// accepted, the line is given DRAIN_CYCLES idle cycles to clear.
//
// Parameters
//   N            number of delay-line taps
//   CW           count width, clog2(N)+1, so that N itself can be represented
//   DRAIN_CYCLES idle cycles after a handshake before IDLE (at least 1)
//
// Ports
//   clk            system clock
//   rst            synchronous active-high reset
//   start_i        measurement request, looked at only in IDLE
//   busy_o         high in every state except IDLE
//   pulse_o        registered launch pulse into the delay line
//   dl_i           delay-line taps (tap 0 nearest the input), asynchronous
//   meas_valid_o   result valid
//   meas_ready_i   result consumer ready
//   meas_count_o   number of ones in the captured code
//   meas_ovf_o     last tap was set, so the pulse ran off the end of the line
//   meas_bubble_o  captured code is not a clean thermometer code

module tdc_meas_ctrl #(
  parameter int N            = 64,
  parameter int CW           = 7,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  output logic          busy_o,
  output logic          pulse_o,
  input  logic [N-1:0]  dl_i,
  output logic          meas_valid_o,
  input  logic          meas_ready_i,
  output logic [CW-1:0] meas_count_o,
  output logic          meas_ovf_o,
  output logic          meas_bubble_o
);

  // The counter needs at least one bit, even when DRAIN_CYCLES is 1.
  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES - 1);
  localparam logic [N-1:0]   ONE_N      = N'(1);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    CAPTURE,
    SYNC,
    VALID,
    DRAIN
  } state_t;

  state_t         state;
  logic [N-1:0]   cap1;
  logic [N-1:0]   cap2;
  logic [DCW-1:0] drain_cnt;
  logic [CW-1:0]  pop_count;
  logic           is_thermo;

  // Popcount and the thermometer check both work from the second
  // synchroniser stage. A clean code has the form 2^k-1. For that form,
  // adding one clears every set bit, so x & (x+1) is zero only for clean
  // codes. All-ones wraps to zero in N bits and also comes out clean.
  always_comb begin
    pop_count = '0;
    for (int i = 0; i < N; i++) begin
      pop_count = pop_count + CW'(cap2[i]);
    end
    is_thermo = ((cap2 & (cap2 + ONE_N)) == '0);
  end

  // Sequencer. Every output is a register. cap1 samples the asynchronous
  // taps exactly one clock after the pulse goes high, so the measured window
  // is one clk period. cap2 is the metastability stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cap1          <= '0;
      cap2          <= '0;
      drain_cnt     <= '0;
      busy_o        <= 1'b0;
      pulse_o       <= 1'b0;
      meas_valid_o  <= 1'b0;
      meas_count_o  <= '0;
      meas_ovf_o    <= 1'b0;
      meas_bubble_o <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_i) begin
            pulse_o <= 1'b1;
            busy_o  <= 1'b1;
            state   <= LAUNCH;
          end
        end
        LAUNCH: begin
          cap1    <= dl_i;
          pulse_o <= 1'b0;
          state   <= CAPTURE;
        end
        CAPTURE: begin
          cap2  <= cap1;
          state <= SYNC;
        end
        SYNC: begin
          meas_count_o  <= pop_count;
          meas_ovf_o    <= cap2[N-1];
          meas_bubble_o <= ~is_thermo;
          meas_valid_o  <= 1'b1;
          state         <= VALID;
        end
        VALID: begin
          if (meas_ready_i) begin
            meas_valid_o <= 1'b0;
            drain_cnt    <= DRAIN_LOAD;
            state        <= DRAIN;
          end
        end
        DRAIN: begin
          // This branch does not look at start_i, so a request made on the
          // exit edge is taken one edge later, from IDLE.
          if (drain_cnt == '0) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// tb_tdc_meas_ctrl
// ----------------
// Self-checking bench for tdc_meas_ctrl with N=8, CW=4, DRAIN_CYCLES=4.
// The bench plays the delay line: it drives dl_i with the wanted code in the
// single cycle where the controller samples it, and with random data at all
// other times. Expected results come from a plain behavioural model of the
// code: count the ones, take the top bit, and look for a zero below a one.

module tb_tdc_meas_ctrl;

  localparam int N  = 8;
  localparam int CW = 4;
  localparam int DC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          busy_o;
  logic          pulse_o;
  logic [N-1:0]  dl_i;
  logic          meas_valid_o;
  logic          meas_ready_i;
  logic [CW-1:0] meas_count_o;
  logic          meas_ovf_o;
  logic          meas_bubble_o;

  int errors = 0;
  int checks = 0;

  // Values recorded by the stimulus tasks, checked by the test tasks.
  logic obs_pulse0, obs_pulse1, obs_busy0, obs_valid_after;
  int   obs_lat, obs_drain;

  tdc_meas_ctrl #(.N(N), .CW(CW), .DRAIN_CYCLES(DC)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .busy_o       (busy_o),
    .pulse_o      (pulse_o),
    .dl_i         (dl_i),
    .meas_valid_o (meas_valid_o),
    .meas_ready_i (meas_ready_i),
    .meas_count_o (meas_count_o),
    .meas_ovf_o   (meas_ovf_o),
    .meas_bubble_o(meas_bubble_o)
  );

  // 10-unit clock; stimulus and sampling both happen on the falling edge.
  always #5 clk = ~clk;

  // Stops a hung run that none of the bounded waits catches.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Behavioural model of the expected result.
  function automatic int model_count(input logic [N-1:0] c);
    int n = 0;
    for (int i = 0; i < N; i++) if (c[i]) n++;
    return n;
  endfunction

  function automatic logic model_bubble(input logic [N-1:0] c);
    for (int j = 0; j < N; j++)
      if (c[j])
        for (int i = 0; i < j; i++)
          if (!c[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Starts one measurement from IDLE and presents `code` at the capture edge.
  // Then waits (bounded) for valid. obs_lat counts the edges after the start
  // edge up to and including the edge that raised valid.
  task automatic launch(input logic [N-1:0] code);
    @(negedge clk);
    start_i = 1'b1;
    dl_i    = N'($urandom);
    @(posedge clk); @(negedge clk);
    start_i    = 1'b0;
    obs_pulse0 = pulse_o;
    obs_busy0  = busy_o;
    dl_i       = code;
    @(posedge clk); @(negedge clk);
    obs_pulse1 = pulse_o;
    dl_i       = N'($urandom);
    obs_lat    = 1;
    while (!meas_valid_o && obs_lat < 12) begin
      @(posedge clk); @(negedge clk);
      obs_lat++;
    end
  endtask

  // Accepts the pending result with a single ready cycle. Then counts
  // (bounded) the edges until busy_o falls.
  task automatic release_result();
    meas_ready_i = 1'b1;
    @(posedge clk); @(negedge clk);
    meas_ready_i    = 1'b0;
    obs_valid_after = meas_valid_o;
    obs_drain       = 0;
    while (busy_o && obs_drain < 20) begin
      @(posedge clk); @(negedge clk);
      obs_drain++;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 40) begin
      @(posedge clk); @(negedge clk);
      n++;
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_timeout: busy_o=%b after %0d cycles, required 0", busy_o, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b1; meas_ready_i = 1'b0; dl_i = N'($urandom);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy_o, pulse_o, meas_valid_o, meas_count_o, meas_ovf_o, meas_bubble_o} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: busy=%b pulse=%b valid=%b count=%0d ovf=%b bubble=%b, required all 0",
               busy_o, pulse_o, meas_valid_o, meas_count_o, meas_ovf_o, meas_bubble_o);
    end
    rst = 1'b0; start_i = 1'b0;
  endtask

  // Fixed codes from the plan first, then random codes. The random ones
  // alternate between raw values and clean thermometer codes.
  task automatic test_codes();
    logic [N-1:0] code;
    logic [N:0]   t;
    for (int k = 0; k < 24; k++) begin
      case (k)
        0: code = 8'b0000_0111;
        1: code = 8'hFF;
        2: code = 8'h00;
        3: code = 8'b0001_1011;
        default: begin
          if (k % 2 == 0) code = N'($urandom);
          else begin
            t    = (9'd1 << $urandom_range(N, 0)) - 9'd1;
            code = t[N-1:0];
          end
        end
      endcase
      launch(code);
      checks++;
      if (obs_pulse0 !== 1'b1 || obs_pulse1 !== 1'b0 || obs_busy0 !== 1'b1) begin
        errors++;
        $display("[TB] FAIL pulse_shape code=%b: pulse E0/E1=%b%b busy=%b, required 10 and busy 1",
                 code, obs_pulse0, obs_pulse1, obs_busy0);
      end
      checks++;
      if (obs_lat !== 3) begin
        errors++;
        $display("[TB] FAIL latency code=%b: got %0d edges, required 3", code, obs_lat);
      end
      checks++;
      if (meas_count_o !== CW'(model_count(code))) begin
        errors++;
        $display("[TB] FAIL count code=%b: got %0d, required %0d", code, meas_count_o, model_count(code));
      end
      checks++;
      if (meas_ovf_o !== code[N-1]) begin
        errors++;
        $display("[TB] FAIL ovf code=%b: got %b, required %b", code, meas_ovf_o, code[N-1]);
      end
      checks++;
      if (meas_bubble_o !== model_bubble(code)) begin
        errors++;
        $display("[TB] FAIL bubble code=%b: got %b, required %b", code, meas_bubble_o, model_bubble(code));
      end
      release_result();
      checks++;
      if (obs_valid_after !== 1'b0 || obs_drain !== DC) begin
        errors++;
        $display("[TB] FAIL handshake code=%b: valid after ready=%b drain=%0d, required 0 and %0d",
                 code, obs_valid_after, obs_drain, DC);
      end
      checks++;
      if (meas_count_o !== CW'(model_count(code))) begin
        errors++;
        $display("[TB] FAIL count_held code=%b: got %0d, required %0d", code, meas_count_o, model_count(code));
      end
    end
  endtask

  // Ready is held low for 10 cycles while start_i pulses. Nothing may move.
  task automatic test_ready_stall();
    logic [N-1:0] code = 8'b0011_1111;
    launch(code);
    checks++;
    if (obs_lat !== 3) begin
      errors++;
      $display("[TB] FAIL stall_latency: got %0d, required 3", obs_lat);
    end
    for (int k = 0; k < 10; k++) begin
      start_i = (k % 3 == 0);
      @(posedge clk); @(negedge clk);
      checks++;
      if ({meas_valid_o, busy_o, pulse_o, meas_count_o, meas_ovf_o, meas_bubble_o} !==
          {1'b1, 1'b1, 1'b0, CW'(model_count(code)), code[N-1], model_bubble(code)}) begin
        errors++;
        $display("[TB] FAIL stall_hold cycle %0d: valid=%b busy=%b pulse=%b count=%0d ovf=%b bubble=%b, required 1 1 0 %0d %b %b",
                 k, meas_valid_o, busy_o, pulse_o, meas_count_o, meas_ovf_o, meas_bubble_o,
                 model_count(code), code[N-1], model_bubble(code));
      end
    end
    start_i = 1'b0;
    release_result();
    checks++;
    if (obs_valid_after !== 1'b0 || obs_drain !== DC) begin
      errors++;
      $display("[TB] FAIL stall_release: valid after ready=%b drain=%0d, required 0 and %0d",
               obs_valid_after, obs_drain, DC);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || pulse_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_no_queue: busy=%b pulse=%b, required 0 0", busy_o, pulse_o);
    end
  endtask

  // start_i and ready are held high. A pulse should appear every 5+DC
  // cycles. Each one-cycle valid is checked against the code that was
  // present at the matching capture edge.
  task automatic test_back_to_back();
    logic [N-1:0] pend[$];
    logic [N-1:0] code;
    int pulses = 0, valids = 0, last_pulse = -1;
    logic prev_valid = 1'b0;
    @(negedge clk);
    start_i = 1'b1; meas_ready_i = 1'b1; dl_i = N'($urandom);
    for (int it = 1; it <= 40; it++) begin
      @(posedge clk); @(negedge clk);
      dl_i = N'($urandom);
      if (pulse_o) begin
        pend.push_back(dl_i);
        if (last_pulse >= 0) begin
          checks++;
          if (it - last_pulse !== 5 + DC) begin
            errors++;
            $display("[TB] FAIL b2b_period: got %0d cycles, required %0d", it - last_pulse, 5 + DC);
          end
        end
        last_pulse = it;
        pulses++;
      end
      if (meas_valid_o) begin
        valids++;
        checks++;
        if (prev_valid) begin
          errors++;
          $display("[TB] FAIL b2b_valid_width: valid high two cycles running at iteration %0d, required 1 cycle", it);
        end
        checks++;
        if (pend.size() == 0) begin
          errors++;
          $display("[TB] FAIL b2b_unexpected_valid: valid with no launch pending at iteration %0d, required none", it);
        end else begin
          code = pend.pop_front();
          if ({meas_count_o, meas_ovf_o, meas_bubble_o} !==
              {CW'(model_count(code)), code[N-1], model_bubble(code)}) begin
            errors++;
            $display("[TB] FAIL b2b_result code=%b: count=%0d ovf=%b bubble=%b, required %0d %b %b",
                     code, meas_count_o, meas_ovf_o, meas_bubble_o,
                     model_count(code), code[N-1], model_bubble(code));
          end
        end
      end
      prev_valid = meas_valid_o;
    end
    checks++;
    if (pulses !== 5 || valids !== 5) begin
      errors++;
      $display("[TB] FAIL b2b_counts: pulses=%0d valids=%0d, required 5 and 5", pulses, valids);
    end
    start_i = 1'b0;
    wait_idle();
    meas_ready_i = 1'b0;
  endtask

  // Reset arrives while the pulse is high. The following measurement must
  // not show anything left over from before the reset.
  task automatic test_reset_mid_launch();
    logic [N-1:0] code = 8'b0000_0011;
    @(negedge clk);
    start_i = 1'b1;
    @(posedge clk); @(negedge clk);
    start_i = 1'b0;
    checks++;
    if (pulse_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_pulse_pre: pulse_o=%b, required 1", pulse_o);
    end
    rst  = 1'b1;
    dl_i = 8'hFF;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy_o, pulse_o, meas_valid_o, meas_count_o, meas_ovf_o, meas_bubble_o} !== '0) begin
      errors++;
      $display("[TB] FAIL midrst_outputs: busy=%b pulse=%b valid=%b count=%0d ovf=%b bubble=%b, required all 0",
               busy_o, pulse_o, meas_valid_o, meas_count_o, meas_ovf_o, meas_bubble_o);
    end
    launch(code);
    checks++;
    if (obs_lat !== 3 || {meas_count_o, meas_ovf_o, meas_bubble_o} !== {CW'(2), 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL midrst_next: lat=%0d count=%0d ovf=%b bubble=%b, required 3 2 0 0",
               obs_lat, meas_count_o, meas_ovf_o, meas_bubble_o);
    end
    release_result();
    checks++;
    if (obs_drain !== DC) begin
      errors++;
      $display("[TB] FAIL midrst_drain: got %0d, required %0d", obs_drain, DC);
    end
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; meas_ready_i = 1'b0; dl_i = '0;
    test_reset();
    test_codes();
    test_ready_stall();
    test_back_to_back();
    test_reset_mid_launch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
